// File: rtl/caf_sweep_ctrl.sv
// ============================================================================
//  Module   : caf_sweep_ctrl
//  Purpose  : Cross-ambiguity sweep sequencer. It steps the frequency shifter
//             through every bin, gates one buffer of samples per bin into
//             argmax, and keeps the global peak (magnitude, index, bin).
//  Option   : CAF_SWEEP_TIMEOUT_EN enables the argmax-result watchdog.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module caf_sweep_ctrl #(
    parameter int BUFFER_LENGTH  = 10,
    parameter int INDEX_BITS     = 4,
    parameter int OUT_MAX_BITS   = 4,
    parameter int FREQ_BINS      = 8,
    parameter int FREQ_BITS      = 3,
    parameter int SETTLE_CYCLES  = 2
`ifdef CAF_SWEEP_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_i,
    output logic                    busy_o,
    output logic [FREQ_BITS-1:0]    freq_bin_o,
    output logic                    freq_load_o,
    input  logic                    src_tvalid_i,
    output logic                    src_tready_o,
    output logic                    am_tvalid_o,
    input  logic                    am_tready_i,
    input  logic                    am_res_valid_i,
    input  logic [OUT_MAX_BITS-1:0] am_max_i,
    input  logic [INDEX_BITS-1:0]   am_index_i,
    output logic                    am_res_ready_o,
    output logic [OUT_MAX_BITS-1:0] best_max_o,
    output logic [INDEX_BITS-1:0]   best_index_o,
    output logic [FREQ_BITS-1:0]    best_bin_o,
`ifdef CAF_SWEEP_TIMEOUT_EN
    output logic                    timeout_err_o,
`endif
    output logic                    result_valid_o,
    input  logic                    result_ready_i
);

    localparam int c_samp_w   = $clog2(BUFFER_LENGTH + 1);
    localparam int c_settle_w = $clog2(SETTLE_CYCLES + 1);
    localparam logic [c_samp_w-1:0]   c_samp_last   = c_samp_w'(BUFFER_LENGTH - 1);
    localparam logic [c_settle_w-1:0] c_settle_last = c_settle_w'(SETTLE_CYCLES - 1);
    localparam logic [FREQ_BITS-1:0]  c_bin_last    = FREQ_BITS'(FREQ_BINS - 1);
`ifdef CAF_SWEEP_TIMEOUT_EN
    localparam int c_wait_w = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_wait_w-1:0]   c_wait_last   = c_wait_w'(TIMEOUT_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETTLE = 3'd2,
        S_STREAM = 3'd3,
        S_WAIT   = 3'd4,
        S_CMP    = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t                  state_q, state_d;
    logic [FREQ_BITS-1:0]    freq_bin_q, freq_bin_d;
    logic [OUT_MAX_BITS-1:0] best_max_q, best_max_d;
    logic [INDEX_BITS-1:0]   best_index_q, best_index_d;
    logic [FREQ_BITS-1:0]    best_bin_q, best_bin_d;
    logic                    first_q, first_d;
    logic [c_settle_w-1:0]   settle_cnt_q, settle_cnt_d;
    logic [c_samp_w-1:0]     samp_cnt_q, samp_cnt_d;
    logic [OUT_MAX_BITS-1:0] res_max_q, res_max_d;
    logic [INDEX_BITS-1:0]   res_index_q, res_index_d;
`ifdef CAF_SWEEP_TIMEOUT_EN
    logic [c_wait_w-1:0]     wait_cnt_q, wait_cnt_d;
    logic                    timeout_err_q, timeout_err_d;
`endif

    logic w_last_bin;
    logic w_xfer;

    assign w_last_bin = (freq_bin_q == c_bin_last);
    assign w_xfer     = src_tvalid_i & am_tready_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            freq_bin_q    <= '0;
            best_max_q    <= '0;
            best_index_q  <= '0;
            best_bin_q    <= '0;
            first_q       <= 1'b0;
            settle_cnt_q  <= '0;
            samp_cnt_q    <= '0;
            res_max_q     <= '0;
            res_index_q   <= '0;
`ifdef CAF_SWEEP_TIMEOUT_EN
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            freq_bin_q    <= freq_bin_d;
            best_max_q    <= best_max_d;
            best_index_q  <= best_index_d;
            best_bin_q    <= best_bin_d;
            first_q       <= first_d;
            settle_cnt_q  <= settle_cnt_d;
            samp_cnt_q    <= samp_cnt_d;
            res_max_q     <= res_max_d;
            res_index_q   <= res_index_d;
`ifdef CAF_SWEEP_TIMEOUT_EN
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    // Counters default to zero so each one restarts cleanly on entering its state.
    always_comb begin
        state_d        = state_q;
        freq_bin_d     = freq_bin_q;
        best_max_d     = best_max_q;
        best_index_d   = best_index_q;
        best_bin_d     = best_bin_q;
        first_d        = first_q;
        settle_cnt_d   = '0;
        samp_cnt_d     = '0;
        res_max_d      = res_max_q;
        res_index_d    = res_index_q;
`ifdef CAF_SWEEP_TIMEOUT_EN
        wait_cnt_d     = '0;
        timeout_err_d  = timeout_err_q;
`endif
        freq_load_o    = 1'b0;
        am_tvalid_o    = 1'b0;
        src_tready_o   = 1'b0;
        am_res_ready_o = 1'b0;
        result_valid_o = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    freq_bin_d    = '0;
                    best_max_d    = '0;
                    best_index_d  = '0;
                    best_bin_d    = '0;
                    first_d       = 1'b0;
`ifdef CAF_SWEEP_TIMEOUT_EN
                    timeout_err_d = 1'b0;
`endif
                    state_d       = S_LOAD;
                end
            end
            S_LOAD: begin
                freq_load_o = 1'b1;
                state_d     = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_cnt_q == c_settle_last) begin
                    state_d = S_STREAM;
                end else begin
                    settle_cnt_d = settle_cnt_q + c_settle_w'(1);
                end
            end
            S_STREAM: begin
                am_tvalid_o  = src_tvalid_i;
                src_tready_o = am_tready_i;
                samp_cnt_d   = samp_cnt_q;
                // The terminal transfer leaves STREAM, so the gate closes the next cycle.
                if (w_xfer) begin
                    if (samp_cnt_q == c_samp_last) begin
                        samp_cnt_d = '0;
                        state_d    = S_WAIT;
                    end else begin
                        samp_cnt_d = samp_cnt_q + c_samp_w'(1);
                    end
                end
            end
            S_WAIT: begin
                am_res_ready_o = 1'b1;
                if (am_res_valid_i) begin
                    res_max_d   = am_max_i;
                    res_index_d = am_index_i;
                    state_d     = S_CMP;
                end
`ifdef CAF_SWEEP_TIMEOUT_EN
                else if (wait_cnt_q == c_wait_last) begin
                    // Missing result: drop this bin and move on as if CMP finished.
                    timeout_err_d = 1'b1;
                    if (w_last_bin) begin
                        state_d = S_DONE;
                    end else begin
                        freq_bin_d = freq_bin_q + FREQ_BITS'(1);
                        state_d    = S_LOAD;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + c_wait_w'(1);
                end
`endif
            end
            S_CMP: begin
                // Strictly greater, so a tie keeps the earlier bin.
                if (!first_q || (res_max_q > best_max_q)) begin
                    best_max_d   = res_max_q;
                    best_index_d = res_index_q;
                    best_bin_d   = freq_bin_q;
                    first_d      = 1'b1;
                end
                if (w_last_bin) begin
                    state_d = S_DONE;
                end else begin
                    freq_bin_d = freq_bin_q + FREQ_BITS'(1);
                    state_d    = S_LOAD;
                end
            end
            S_DONE: begin
                result_valid_o = 1'b1;
                if (result_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy_o        = (state_q != S_IDLE);
    assign freq_bin_o    = freq_bin_q;
    assign best_max_o    = best_max_q;
    assign best_index_o  = best_index_q;
    assign best_bin_o    = best_bin_q;
`ifdef CAF_SWEEP_TIMEOUT_EN
    assign timeout_err_o = timeout_err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_caf_sweep_ctrl.sv
// ============================================================================
//  Module   : tb_caf_sweep_ctrl
//  Purpose  : Directed-vector bench for caf_sweep_ctrl (four-bin sweep).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_caf_sweep_ctrl;

    localparam int BL = 10;
    localparam int IB = 4;
    localparam int MB = 4;
    localparam int NB = 4;
    localparam int FB = 2;
    localparam int SC = 2;

    logic          clk = 1'b0;
    logic          reset, start, src_tvalid, am_tready, am_res_valid, result_ready;
    logic [MB-1:0] am_max;
    logic [IB-1:0] am_index;
    logic          busy, freq_load, src_tready, am_tvalid, am_res_ready, result_valid;
    logic [FB-1:0] freq_bin, best_bin;
    logic [MB-1:0] best_max;
    logic [IB-1:0] best_index;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [NB-1:0][MB-1:0] mx;
        logic [NB-1:0][IB-1:0] ix;
        logic [MB-1:0]         e_max;
        logic [IB-1:0]         e_ix;
        logic [FB-1:0]         e_bin;
        int                    stall;
        int                    rdelay;
    } vec_t;

    vec_t vecs[5];

    caf_sweep_ctrl #(
        .BUFFER_LENGTH (BL),
        .INDEX_BITS    (IB),
        .OUT_MAX_BITS  (MB),
        .FREQ_BINS     (NB),
        .FREQ_BITS     (FB),
        .SETTLE_CYCLES (SC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start_i        (start),
        .busy_o         (busy),
        .freq_bin_o     (freq_bin),
        .freq_load_o    (freq_load),
        .src_tvalid_i   (src_tvalid),
        .src_tready_o   (src_tready),
        .am_tvalid_o    (am_tvalid),
        .am_tready_i    (am_tready),
        .am_res_valid_i (am_res_valid),
        .am_max_i       (am_max),
        .am_index_i     (am_index),
        .am_res_ready_o (am_res_ready),
        .best_max_o     (best_max),
        .best_index_o   (best_index),
        .best_bin_o     (best_bin),
        .result_valid_o (result_valid),
        .result_ready_i (result_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic setv(input int n, input int m0, input int i0, input int m1, input int i1,
                        input int m2, input int i2, input int m3, input int i3,
                        input int em, input int ei, input int eb, input int st, input int rd);
        vecs[n].mx[0] = MB'(m0); vecs[n].ix[0] = IB'(i0);
        vecs[n].mx[1] = MB'(m1); vecs[n].ix[1] = IB'(i1);
        vecs[n].mx[2] = MB'(m2); vecs[n].ix[2] = IB'(i2);
        vecs[n].mx[3] = MB'(m3); vecs[n].ix[3] = IB'(i3);
        vecs[n].e_max = MB'(em);
        vecs[n].e_ix  = IB'(ei);
        vecs[n].e_bin = FB'(eb);
        vecs[n].stall  = st;
        vecs[n].rdelay = rd;
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({busy, freq_bin, freq_load, src_tready, am_tvalid, am_res_ready,
                    best_max, best_index, best_bin, result_valid});
    endfunction

    // One full sweep driven by vector v; abort_bin >= 0 pulses reset mid-STREAM of that bin.
    task automatic run_sweep(input int v, input int abort_bin);
        int loads = 0, xfers = 0, extra = 0, bad_pt = 0, bad_tm = 0, bad_x = 0;
        int load_cyc = 0, res_cyc = -10, done_cyc = -1, wc = 0, bad_st = 0;
        bit first_v = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        #1;
        chk("start_to_load", 32'(freq_load), 32'd1);
        for (int cyc = 1; cyc < 3000 && done_cyc < 0; cyc++) begin
            if (cyc > 1) begin
                @(posedge clk);
                #1 am_tready = ~am_tready;
                #1;
            end
            am_res_valid = 1'b0;
            start = 1'b0;
            if (freq_load) begin
                if (freq_bin !== FB'(loads)) bad_tm++;
                if (loads > 0 && cyc != res_cyc + 2) bad_tm++;
                loads++;
                load_cyc = cyc;
                xfers = 0;
                wc = 0;
                first_v = 1'b0;
            end
            if (am_tvalid) begin
                if (!first_v) begin
                    first_v = 1'b1;
                    if (cyc != load_cyc + 1 + SC) bad_tm++;
                end
                if (src_tready !== am_tready) bad_pt++;
                if (am_res_ready) bad_pt++;
                if (xfers >= BL) extra++;
                if (am_tready) xfers++;
            end else if (src_tready) begin
                bad_pt++;
            end
            if (abort_bin >= 0 && loads - 1 == abort_bin && xfers == 3 && am_tvalid) begin
                reset = 1'b1;
                @(posedge clk);
                #1 reset = 1'b0;
                #1;
                chk("reset_mid_stream_outs", all_outs(), 32'd0);
                @(posedge clk);
                #2;
                chk("reset_stays_idle", 32'(busy), 32'd0);
                return;
            end
            if (am_res_ready) begin
                wc++;
                if (wc > vecs[v].rdelay && loads >= 1 && loads <= NB) begin
                    if (xfers != BL) bad_x++;
                    am_max = vecs[v].mx[loads-1];
                    am_index = vecs[v].ix[loads-1];
                    am_res_valid = 1'b1;
                    res_cyc = cyc;
                end
            end
            if (loads == 2 && xfers == 5) start = 1'b1;
            if (result_valid) begin
                done_cyc = cyc;
                if (cyc != res_cyc + 2) bad_tm++;
            end
        end
        start = 1'b0;
        am_res_valid = 1'b0;
        chk("sweep_reached_done", 32'(done_cyc >= 0), 32'd1);
        chk("freq_load_count", 32'(loads), 32'(NB));
        chk("samples_per_bin_errs", 32'(bad_x), 32'd0);
        chk("tvalid_after_last_errs", 32'(extra), 32'd0);
        chk("passthrough_errs", 32'(bad_pt), 32'd0);
        chk("timing_errs", 32'(bad_tm), 32'd0);
        chk("best_max", 32'(best_max), 32'(vecs[v].e_max));
        chk("best_index", 32'(best_index), 32'(vecs[v].e_ix));
        chk("best_bin", 32'(best_bin), 32'(vecs[v].e_bin));
        result_ready = 1'b0;
        for (int k = 0; k < vecs[v].stall; k++) begin
            @(posedge clk);
            #2;
            if (!(result_valid && busy && best_max === vecs[v].e_max &&
                  best_index === vecs[v].e_ix && best_bin === vecs[v].e_bin)) bad_st++;
        end
        chk("stall_hold_errs", 32'(bad_st), 32'd0);
        result_ready = 1'b1;
        @(posedge clk);
        #1 result_ready = 1'b0;
        #1;
        chk("busy_after_handshake", 32'({busy, result_valid}), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        setv(0, 3, 2, 9, 5, 7, 1, 9, 8,   9, 5, 1,  5, 0);
        setv(1, 0, 4, 0, 1, 0, 2, 0, 3,   0, 4, 0,  0, 2);
        setv(2, 1, 1, 2, 2, 3, 3, 15, 9,  15, 9, 3, 0, 1);
        setv(3, 15, 0, 14, 1, 15, 2, 0, 3, 15, 0, 0, 1, 0);
        setv(4, 0, 7, 0, 6, 1, 5, 0, 4,   1, 5, 2,  2, 3);

        reset        = 1'b1;
        start        = 1'b0;
        src_tvalid   = 1'b1;
        am_tready    = 1'b1;
        am_res_valid = 1'b0;
        am_max       = '0;
        am_index     = '0;
        result_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("reset_outs", all_outs(), 32'd0);
        @(posedge clk);
        #2;
        chk("idle_without_start", 32'(busy), 32'd0);

        for (int i = 0; i < 5; i++) begin
            run_sweep(i, -1);
        end
        run_sweep(0, 2);
        run_sweep(2, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/caf_sweep_ctrl.md
# caf_sweep_ctrl

Sequencer for a cross-ambiguity sweep: steps an upstream frequency shifter through `freq_bins` bins and, for each bin, gates exactly `buffer_length` samples into the argmax stage. It collects each per-bin argmax result and keeps the global peak: magnitude, time index and frequency bin. The final peak is presented on a valid/ready result port. It sits between the sample source/frequency shifter and the argmax block, and owns both of their handshakes.

## Interface
- `buffer_length`, 10, samples per bin; must match the argmax instance.
- `index_bits`, 4, width of the argmax time index.
- `out_max_bits`, 4, width of the argmax magnitude.
- `freq_bins`, 8, number of frequency bins per sweep (≥1).
- `freq_bits`, 3, width of the bin number; ≥ clog2(`freq_bins`).
- `settle_cycles`, 2, idle cycles after a bin load before streaming (≥1).
- `timeout_cycles`, 64, result watchdog limit; used only with the macro.

Ports:
- `clk` in 1: single clock, all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: sampled in IDLE only; begins a sweep.
- `busy` out 1: high in every state except IDLE.
- `freq_bin` out `freq_bits`: bin number for the shifter.
- `freq_load` out 1: one-cycle strobe, `freq_bin` is valid.
- `src_tvalid` in 1 / `src_tready` out 1: sample source handshake.
- `am_tvalid` out 1 / `am_tready` in 1: sample handshake into argmax.
- `am_res_valid` in 1, `am_max` in `out_max_bits`, `am_index` in `index_bits`, `am_res_ready` out 1: argmax result handshake.
- `best_max` out `out_max_bits`, `best_index` out `index_bits`, `best_bin` out `freq_bits`: global peak.
- `result_valid` out 1 / `result_ready` in 1: result handshake.
- `timeout_err` out 1: sticky per sweep; exists only with the macro.

## Operation
- States: IDLE, LOAD, SETTLE, STREAM, WAIT, CMP, DONE.
- IDLE, on `start`:
  - clear `freq_bin` and the best registers;
  - clear the `first` flag;
  - go to LOAD.
- LOAD: `freq_load`=1 for exactly one cycle, then SETTLE.
- SETTLE: count `settle_cycles` cycles, then STREAM.
- STREAM: combinational pass-through.
  - `am_tvalid`=`src_tvalid` and `src_tready`=`am_tready`.
  - The sample counter increments on `src_tvalid & am_tready`.
  - When the counter reaches `buffer_length`, force both signals low from the next cycle, then go to WAIT.
  - Outside STREAM, `am_tvalid`=0 and `src_tready`=0.
- WAIT: `am_res_ready`=1. On `am_res_valid`, register `am_max` and `am_index`, then go to CMP.
- CMP: update best if `first`==0 or `am_max` > `best_max` (strictly greater).
  - Ties keep the earlier bin. The first bin always loads.
  - If `freq_bin` == `freq_bins`-1, go to DONE.
  - Otherwise increment `freq_bin` and go to LOAD.
- DONE: `result_valid`=1 and the best outputs are held stable. On `result_ready`, go to IDLE.
- `start` outside IDLE is ignored.
- Unsigned compare at `out_max_bits` width.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0.
- `reset` mid-sweep aborts on the next edge; samples and results in flight are dropped.
- `start` at edge N: `freq_load` is high in cycle N+1; streaming is allowed from cycle N+2+`settle_cycles`.
- The sample counter never exceeds `buffer_length`. A transfer on the terminal cycle is counted, and no transfer is allowed on the following cycle.
- CMP takes 1 cycle. Bin-to-bin overhead with no stalls: result + CMP + LOAD + `settle_cycles`.
- `result_valid` stays high until `result_ready`. Outputs hold while it is stalled.
- `am_res_valid` arriving outside WAIT is not acknowledged (`am_res_ready`=0).

## Configuration
- `CAF_SWEEP_TIMEOUT_EN` defined:
  - WAIT counts cycles; the count is cleared on entering WAIT.
  - If `timeout_cycles` pass without `am_res_valid`, set `timeout_err`, skip the compare for that bin, and continue as if CMP completed.
  - `timeout_err` clears on `start`/`reset`.
- Not defined: WAIT blocks indefinitely; no `timeout_err` port and no counter.

## Test plan
- `freq_bins`=4; per-bin results (max,index) = (3,2),(9,5),(7,1),(9,8) -> `best_max`=9, `best_index`=5, `best_bin`=1 (tie keeps the earlier bin).
- `src_tvalid` held high, `am_tready` toggled every cycle -> exactly 10 samples transferred per bin, `am_tvalid` low after the 10th; 4 `freq_load` pulses with `freq_bin` 0..3.
- `result_ready` held low 5 cycles in DONE -> `result_valid` stays high with outputs stable; `busy` falls the cycle after the handshake.
- `reset` pulsed during STREAM of bin 2 -> next cycle all outputs 0 and state IDLE; a fresh `start` restarts at `freq_bin`=0.
- All bins return `am_max`=0 -> `best_max`=0, `best_bin`=0, `best_index` from bin 0 (`first` forces the load).
- With `CAF_SWEEP_TIMEOUT_EN`, `timeout_cycles`=64: bin 1 result withheld -> `timeout_err`=1 at WAIT cycle 64, sweep completes with the best taken from bins 0, 2 and 3.
